// File: rtl/cacheline_burst_adaptor_pkg.sv
// Shared types for the cache-line burst adaptor: line/beat/address widths,
// the adaptor state encoding and small address/beat helpers.
package adaptor_types;

   localparam int BEATS    = 4;
   localparam int BEAT_W   = 64;
   localparam int OFFSET_W = 5;
   localparam int LINE_W   = BEATS * BEAT_W;
   localparam int ADDR_W   = 32;
   localparam int CNT_W    = 2;

   typedef logic [BEAT_W-1:0] beat_t;
   typedef logic [LINE_W-1:0] line_t;
   typedef logic [ADDR_W-1:0] addr_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } adaptor_state_t;

   // Index of the final beat of a line; the counter wraps past it on exit.
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   // Mask covering the byte-offset bits inside one cache line.
   localparam addr_t OFFSET_MASK = addr_t'((1 << OFFSET_W) - 1);

   // Clear the byte offset so the burst always starts on a line boundary.
   function automatic addr_t line_align(input addr_t a);
      return a & ~OFFSET_MASK;
   endfunction

   // Bit position of beat 'idx' inside a line.
   function automatic int beat_lsb(input logic [CNT_W-1:0] idx);
      return int'(idx) * BEAT_W;
   endfunction

endpackage

// File: rtl/cacheline_burst_adaptor.sv
// Cache-line to memory-burst adaptor.
// Takes one 256-bit line read or write from the arbiter, runs it as a
// 4-beat, 64-bit burst on the physical-memory bus, then pulses cache_resp
// for one cycle.
//
// Handshake: cache_read/cache_write are levels held by the arbiter until
// cache_resp and are only sampled in IDLE. On the memory side mem_read /
// mem_write stay high for the whole burst; every cycle with mem_resp=1
// moves exactly one beat (read beat valid on burst_i, or write beat on
// burst_o consumed). Cycles with mem_resp=0 are gaps and move nothing.
module cacheline_burst_adaptor
   import adaptor_types::*;
(
   input  logic  clk,
   input  logic  rst,
   input  addr_t cache_address,
   input  line_t cache_to_pmem,
   output line_t pmem_to_cache,
   input  logic  cache_read,
   input  logic  cache_write,
   output logic  cache_resp,
   input  beat_t burst_i,
   output beat_t burst_o,
   output addr_t mem_address,
   output logic  mem_read,
   output logic  mem_write,
   input  logic  mem_resp
);

   adaptor_state_t   state;
   adaptor_state_t   state_next;
   logic [CNT_W-1:0] cnt;
   addr_t            addr_q;
   line_t            wr_buf;
   line_t            rd_buf;
   logic             req_any;
   logic             req_accept;
   logic             in_burst;
   logic             beat_move;
   logic             last_beat;
   logic             req_conflict;

   assign req_any      = cache_read | cache_write;
   assign req_accept   = (state == ST_IDLE) && req_any;
   assign in_burst     = (state == ST_READ) || (state == ST_WRITE);
   assign beat_move    = in_burst && mem_resp;
   assign last_beat    = beat_move && (cnt == LAST_BEAT);
   assign req_conflict = cache_read & cache_write;

   // Read data is presented straight from the capture buffer, so it stays
   // valid after DONE until a later read overwrites its first beat.
   assign pmem_to_cache = rd_buf;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; a write wins when both requests are high.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (cache_write) begin
               state_next = ST_WRITE;
            end else if (cache_read) begin
               state_next = ST_READ;
            end
         end
         ST_READ: begin
            if (last_beat) begin
               state_next = ST_DONE;
            end
         end
         ST_WRITE: begin
            if (last_beat) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Output decode; every output is zero outside its owning state.
   always_comb begin
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_address = '0;
      burst_o     = '0;
      cache_resp  = 1'b0;
      case (state)
         ST_READ: begin
            mem_read    = 1'b1;
            mem_address = addr_q;
         end
         ST_WRITE: begin
            mem_write   = 1'b1;
            mem_address = addr_q;
            burst_o     = wr_buf[beat_lsb(cnt) +: BEAT_W];
         end
         ST_DONE: begin
            cache_resp = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Request capture and beat counter; the counter only moves mid-burst
   // and its natural 3->0 wrap coincides with leaving the burst.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt    <= '0;
         addr_q <= '0;
         wr_buf <= '0;
      end else if (req_accept) begin
         cnt    <= '0;
         addr_q <= line_align(cache_address);
         if (cache_write) begin
            wr_buf <= cache_to_pmem;
         end
      end else if (beat_move) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Read beat capture into the slot selected by the beat counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_buf <= '0;
      end else if ((state == ST_READ) && mem_resp) begin
         rd_buf[beat_lsb(cnt) +: BEAT_W] <= burst_i;
      end
   end

   // Both requests high at once is an arbiter bug; the write still proceeds.
   a_no_dual_request : assert property (
      @(posedge clk) disable iff (!rst) !req_conflict
   ) else $warning("cache_read and cache_write both high; write taken");

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed bench for cacheline_burst_adaptor: reads with and without gaps,
// a write burst, reset mid-burst, back-to-back requests and the dual-request
// case, all against hand-computed lines, addresses and latencies.
module tb_cacheline_burst_adaptor;
   import adaptor_types::*;

   logic  clk = 1'b0;
   logic  rst;
   addr_t cache_address;
   line_t cache_to_pmem;
   line_t pmem_to_cache;
   logic  cache_read;
   logic  cache_write;
   logic  cache_resp;
   beat_t burst_i;
   beat_t burst_o;
   addr_t mem_address;
   logic  mem_read;
   logic  mem_write;
   logic  mem_resp;

   int n_checks = 0;
   int n_fail   = 0;

   logic [BEAT_W-1:0] exp_q[$];

   // Clock / reset block
   always #5 clk = ~clk;

   cacheline_burst_adaptor dut (
      .clk           (clk),
      .rst           (rst),
      .cache_address (cache_address),
      .cache_to_pmem (cache_to_pmem),
      .pmem_to_cache (pmem_to_cache),
      .cache_read    (cache_read),
      .cache_write   (cache_write),
      .cache_resp    (cache_resp),
      .burst_i       (burst_i),
      .burst_o       (burst_o),
      .mem_address   (mem_address),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_resp      (mem_resp)
   );

   task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                        input logic [LINE_W-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Driver: line read. Called at a negedge; returns at a negedge one cycle
   // after the resp cycle. pat gives mem_resp per READ cycle, LSB first.
   task automatic do_read(input string tag, input addr_t a, input addr_t exp_addr,
                          input line_t line, input line_t prev,
                          input logic [15:0] pat, input int exp_lat);
      int lat  = 0;
      int beat = 0;
      int k    = 0;
      bit got  = 1'b0;
      cache_address = a;
      cache_read    = 1'b1;
      cache_write   = 1'b0;
      mem_resp      = 1'b0;
      while (!got && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (cache_resp) begin
            got = 1'b1;
         end else begin
            if (lat == 1) begin
               check({tag, "_mem_read"}, mem_read, 1);
               check({tag, "_mem_addr"}, mem_address, exp_addr);
               check({tag, "_prev_line"}, pmem_to_cache, prev);
            end
            mem_resp = (beat < BEATS) && pat[k];
            if (k < 15) k++;
            if (mem_resp) begin
               burst_i = line[beat*BEAT_W +: BEAT_W];
               beat++;
            end else begin
               burst_i = '0;
            end
         end
      end
      mem_resp   = 1'b0;
      burst_i    = '0;
      cache_read = 1'b0;
      check({tag, "_resp_seen"}, got, 1);
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_line"}, pmem_to_cache, line);
      check({tag, "_mem_read_done"}, mem_read, 0);
      @(negedge clk);
      check({tag, "_single_pulse"}, cache_resp, 0);
      check({tag, "_line_hold"}, pmem_to_cache, line);
   endtask

   // Driver: line write, with optional simultaneous cache_read.
   task automatic do_write(input string tag, input addr_t a, input addr_t exp_addr,
                           input line_t line, input logic [15:0] pat,
                           input int exp_lat, input bit also_read);
      int lat = 0;
      int k   = 0;
      bit got = 1'b0;
      exp_q.delete();
      for (int i = 0; i < BEATS; i++) exp_q.push_back(line[i*BEAT_W +: BEAT_W]);
      cache_address = a;
      cache_to_pmem = line;
      cache_write   = 1'b1;
      cache_read    = also_read;
      mem_resp      = 1'b0;
      while (!got && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (cache_resp) begin
            got = 1'b1;
         end else begin
            if (lat == 1) begin
               check({tag, "_mem_write"}, mem_write, 1);
               check({tag, "_mem_read_low"}, mem_read, 0);
               check({tag, "_mem_addr"}, mem_address, exp_addr);
               cache_read = 1'b0;
            end
            mem_resp = (exp_q.size() > 0) && pat[k];
            if (k < 15) k++;
            if (mem_resp) check({tag, "_beat"}, burst_o, exp_q.pop_front());
         end
      end
      mem_resp    = 1'b0;
      cache_write = 1'b0;
      check({tag, "_resp_seen"}, got, 1);
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_beats_left"}, exp_q.size(), 0);
      check({tag, "_mem_write_done"}, mem_write, 0);
      @(negedge clk);
      check({tag, "_single_pulse"}, cache_resp, 0);
   endtask

   line_t line1, line2, line3, line4, line_w, line_w2;

   initial begin
      line1   = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      line2   = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                 64'hDEAD_BEEF_CAFE_F00D, 64'h0F1E_2D3C_4B5A_6978};
      line_w  = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
      line3   = {64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
                 64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888};
      line4   = {64'h9999_0000_9999_0000, 64'hAAAA_5555_AAAA_5555,
                 64'h1234_5678_1234_5678, 64'h0BAD_F00D_0BAD_F00D};
      line_w2 = {64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003,
                 64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001};

      rst           = 1'b0;
      cache_address = '0;
      cache_to_pmem = '0;
      cache_read    = 1'b0;
      cache_write   = 1'b0;
      burst_i       = '0;
      mem_resp      = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_cache_resp", cache_resp, 0);
      check("rst_mem_read", mem_read, 0);
      check("rst_mem_write", mem_write, 0);
      check("rst_mem_addr", mem_address, 0);
      check("rst_burst_o", burst_o, 0);
      check("rst_pmem", pmem_to_cache, 0);
      rst = 1'b1;

      // mem_resp in IDLE must be ignored
      mem_resp = 1'b1;
      burst_i  = 64'hFFFF_FFFF_FFFF_FFFF;
      repeat (2) @(negedge clk);
      check("idle_resp_mem_read", mem_read, 0);
      check("idle_resp_cache_resp", cache_resp, 0);
      check("idle_resp_pmem", pmem_to_cache, 0);
      mem_resp = 1'b0;
      burst_i  = '0;

      do_read("rd_contig", 32'h0000_1234, 32'h0000_1220, line1, '0, 16'hFFFF, 5);
      do_read("rd_gaps", 32'h8000_003F, 32'h8000_0020, line2, line1, 16'h0065, 8);
      do_write("wr", 32'h0000_0045, 32'h0000_0040, line_w, 16'hFFFF, 5, 1'b0);
      // read requested in the cycle right after the write's resp cycle
      do_read("rd_b2b", 32'h0000_ABCD, 32'h0000_ABC0, line3, line2, 16'hFFFF, 5);

      // reset while three beats of a read have been captured
      cache_address = 32'h0000_2468;
      cache_read    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         mem_resp = 1'b1;
         burst_i  = line3[i*BEAT_W +: BEAT_W];
         @(posedge clk);
         @(negedge clk);
      end
      mem_resp = 1'b0;
      burst_i  = '0;
      check("midrst_mem_read_pre", mem_read, 1);
      rst = 1'b0;
      #1;
      check("midrst_mem_read", mem_read, 0);
      check("midrst_cache_resp", cache_resp, 0);
      check("midrst_mem_addr", mem_address, 0);
      check("midrst_pmem", pmem_to_cache, 0);
      cache_read = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      do_read("rd_fresh", 32'h0000_2468, 32'h0000_2460, line4, '0, 16'hFFFF, 5);

      // both requests high: the write is taken
      do_write("both_req", 32'h0000_011F, 32'h0000_0100, line_w2, 16'hFFFF, 5, 1'b1);
      check("both_req_pmem_kept", pmem_to_cache, line4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
